// File: rtl/div_clk_monitor.sv
// div_clk_monitor: watches a divided clock generated in the i_clk domain.
// Produces registered rise/fall strobes for use as clock enables, measures
// the divided period (and optionally the high time), declares lock after
// LOCK_CNT consecutive periods equal to EXP_PERIOD, and raises a sticky
// error on any deviation or stall once locked.
//
// Optional feature macro: DIV_CLK_MON_DUTY_EN
//   defined   -> high-time counter, o_high reporting and duty checking
//   undefined -> no high-time counter, o_high tied to 0
//
// Ports:
//   i_clk        clock for all logic
//   i_rst        synchronous active-high reset
//   i_div_clk    divided clock, sampled as data
//   i_en         monitor enable
//   i_err_clr    clears o_err (a simultaneous set wins)
//   o_rise       one-cycle strobe per rising edge
//   o_fall       one-cycle strobe per falling edge
//   o_period     last measured period in i_clk cycles
//   o_period_vld one-cycle strobe when o_period updates
//   o_high       last measured high time (0 without the duty feature)
//   o_locked     period stable at EXP_PERIOD
//   o_err        sticky error flag
module div_clk_monitor #(
  parameter int unsigned EXP_PERIOD = 6,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_clk,
  input  logic             i_en,
  input  logic             i_err_clr,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic [CNT_W-1:0] o_high,
  output logic             o_locked,
  output logic             o_err
);

  localparam int unsigned      MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_PERIOD);
  localparam logic [MC_W-1:0]  LOCK_VAL = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t            state;
  logic              d_q;
  logic [CNT_W-1:0]  per_cnt;
  logic [MC_W-1:0]   match_cnt;
  logic              err_set_q;

  logic rise_c;
  logic fall_c;
  logic active_c;
  logic tracking_c;
  logic per_ok_c;
  logic duty_bad_c;

  // Edge detection against the previous sample of the divided clock
  assign rise_c     = i_div_clk & ~d_q;
  assign fall_c     = ~i_div_clk & d_q;
  assign active_c   = i_en && (state != IDLE);
  assign tracking_c = i_en && ((state == MEASURE) || (state == LOCKED));
  assign per_ok_c   = (per_cnt == EXP_VAL);

`ifdef DIV_CLK_MON_DUTY_EN
  localparam logic [CNT_W-1:0] HIGH_VAL = CNT_W'(EXP_PERIOD / 2);

  logic [CNT_W-1:0] hi_cnt;

  // High-time counter: restarts on every rise, reported on every fall
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_cnt <= '0;
      o_high <= '0;
    end else if (!active_c) begin
      hi_cnt <= '0;
    end else begin
      if (rise_c) begin
        hi_cnt <= CNT_W'(1);
      end else if (hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
      if (fall_c && tracking_c) begin
        o_high <= hi_cnt;
      end
    end
  end

  assign duty_bad_c = tracking_c && fall_c && (hi_cnt != HIGH_VAL);
`else
  assign o_high     = '0;
  assign duty_bad_c = 1'b0;
`endif

  // Monitor FSM with period counter; lock/error outputs lag the deciding
  // edge by one cycle so they follow the o_period_vld that caused them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      d_q          <= 1'b0;
      per_cnt      <= '0;
      match_cnt    <= '0;
      err_set_q    <= 1'b0;
      o_rise       <= 1'b0;
      o_fall       <= 1'b0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      d_q          <= i_div_clk;
      o_rise       <= active_c && rise_c;
      o_fall       <= active_c && fall_c;
      o_period_vld <= 1'b0;
      o_locked     <= i_en && (state == LOCKED);
      err_set_q    <= 1'b0;

      // Set wins over clear
      if (err_set_q) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end

      if (!i_en) begin
        state     <= IDLE;
        per_cnt   <= '0;
        match_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            // First rise only starts the count; the partial interval is dropped
            if (rise_c) begin
              per_cnt <= CNT_W'(1);
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise_c) begin
              o_period     <= per_cnt;
              o_period_vld <= 1'b1;
              per_cnt      <= CNT_W'(1);
              if (per_ok_c) begin
                match_cnt <= match_cnt + MC_W'(1);
                if ((match_cnt + MC_W'(1)) == LOCK_VAL) begin
                  state <= LOCKED;
                end
              end else begin
                match_cnt <= '0;
              end
            end else begin
              if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
              end
              if (duty_bad_c) begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (rise_c) begin
              o_period     <= per_cnt;
              o_period_vld <= 1'b1;
              per_cnt      <= CNT_W'(1);
              if (!per_ok_c) begin
                err_set_q <= 1'b1;
                match_cnt <= '0;
                state     <= MEASURE;
              end
            end else if (per_cnt == CNT_MAX) begin
              // Divided clock stalled: rearm on the next rise
              err_set_q <= 1'b1;
              match_cnt <= '0;
              per_cnt   <= '0;
              state     <= ARM;
            end else begin
              per_cnt <= per_cnt + CNT_W'(1);
              if (duty_bad_c) begin
                err_set_q <= 1'b1;
                match_cnt <= '0;
                state     <= MEASURE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor. A timestamp-based reference model
// (rise times, gaps, match count) predicts every output after every edge.
module tb_div_clk_monitor;

  localparam int unsigned EXP_PERIOD = 6;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int          MAXV       = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;
  localparam int M_LOCK = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_clk;
  logic             en;
  logic             err_clr;
  logic             o_rise;
  logic             o_fall;
  logic [CNT_W-1:0] o_period;
  logic             o_period_vld;
  logic [CNT_W-1:0] o_high;
  logic             o_locked;
  logic             o_err;

  div_clk_monitor #(
    .EXP_PERIOD(EXP_PERIOD),
    .CNT_W     (CNT_W),
    .LOCK_CNT  (LOCK_CNT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_div_clk   (div_clk),
    .i_en        (en),
    .i_err_clr   (err_clr),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_period    (o_period),
    .o_period_vld(o_period_vld),
    .o_high      (o_high),
    .o_locked    (o_locked),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int mt, m_last_rise, m_hi_start, m_matches, m_mode;
  bit m_prev, m_err_evt;
  bit e_rise, e_fall, e_vld, e_locked, e_err;
  int e_period, e_high;

  logic [2*CNT_W+4:0] dut_vec;
  logic [2*CNT_W+4:0] exp_vec;
  assign dut_vec = {o_rise, o_fall, o_period_vld, o_locked, o_err, o_period, o_high};
  assign exp_vec = {e_rise, e_fall, e_vld, e_locked, e_err, CNT_W'(e_period), CNT_W'(e_high)};

  // Stimulus queues: level, enable, error clear per cycle
  bit wq[$];
  bit eq[$];
  bit cq[$];

  function automatic void clear_q();
    wq.delete(); eq.delete(); cq.delete();
  endfunction

  function automatic void add_level(bit lvl, int n);
    for (int k = 0; k < n; k++) begin
      wq.push_back(lvl); eq.push_back(1'b1); cq.push_back(1'b0);
    end
  endfunction

  function automatic void add_period(int hi, int lo);
    add_level(1'b1, hi);
    add_level(1'b0, lo);
  endfunction

  task automatic model_reset();
    mt = 0; m_last_rise = 0; m_hi_start = 0; m_matches = 0; m_mode = M_IDLE;
    m_prev = 1'b0; m_err_evt = 1'b0;
    e_rise = 1'b0; e_fall = 1'b0; e_vld = 1'b0; e_locked = 1'b0; e_err = 1'b0;
    e_period = 0; e_high = 0;
  endtask

  // Predict the outputs visible after one clock edge with these inputs
  task automatic model_edge(input bit lvl, input bit e, input bit c);
    bit rise, fall, active, track, ok;
    int gap, hi;
    rise   = lvl && !m_prev;
    fall   = !lvl && m_prev;
    active = e && (m_mode != M_IDLE);
    track  = e && (m_mode == M_MEAS || m_mode == M_LOCK);
    gap    = mt - m_last_rise;
    hi     = mt - m_hi_start;
    if (hi > MAXV) hi = MAXV;
    e_rise   = active && rise;
    e_fall   = active && fall;
    e_vld    = 1'b0;
    e_locked = e && (m_mode == M_LOCK);
    if (m_err_evt) e_err = 1'b1;
    else if (c) e_err = 1'b0;
    m_err_evt = 1'b0;
`ifdef DIV_CLK_MON_DUTY_EN
    if (track && fall) e_high = hi;
`endif
    if (active && rise) m_hi_start = mt;
    if (!e) begin
      m_mode = M_IDLE; m_matches = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARM;
    end else if (m_mode == M_ARM) begin
      if (rise) begin m_last_rise = mt; m_mode = M_MEAS; end
    end else if (rise) begin
      e_vld = 1'b1;
      e_period = (gap > MAXV) ? MAXV : gap;
      m_last_rise = mt;
      ok = (gap == int'(EXP_PERIOD));
      if (m_mode == M_MEAS) begin
        m_matches = ok ? m_matches + 1 : 0;
        if (m_matches >= int'(LOCK_CNT)) m_mode = M_LOCK;
      end else if (!ok) begin
        m_err_evt = 1'b1; m_matches = 0; m_mode = M_MEAS;
      end
    end else if (m_mode == M_LOCK && gap >= MAXV) begin
      m_err_evt = 1'b1; m_matches = 0; m_mode = M_ARM;
    end
`ifdef DIV_CLK_MON_DUTY_EN
    else if (fall && hi != int'(EXP_PERIOD / 2)) begin
      if (m_mode == M_MEAS) m_matches = 0;
      else begin m_err_evt = 1'b1; m_matches = 0; m_mode = M_MEAS; end
    end
`endif
    m_prev = lvl;
    mt++;
  endtask

  task automatic step(input bit lvl, input bit e, input bit c);
    div_clk = lvl; en = e; err_clr = c;
    model_edge(lvl, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      div_clk = 1'($urandom); en = 1'($urandom); err_clr = 1'($urandom);
      model_reset();
      @(posedge clk);
      #1;
      n_vec++;
      if (dut_vec !== '0) begin
        n_err++;
        $display("FAIL reset cycle=%0d got=%h exp=0", k, dut_vec);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stuck_high();
    int rises;
    rises = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0);
      rises += int'(o_rise);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL stuck_high t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (rises != 0) begin
      n_err++;
      $display("FAIL stuck_high_rises got=%0d exp=0", rises);
    end
  endtask

  task automatic test_lock();
    int vlds;
    vlds = 0;
    clear_q();
    add_level(1'b0, 1 + $urandom_range(0, 4));
    repeat (7) add_period(3, 3);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      vlds += int'(o_period_vld);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL lock t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (vlds != 6) begin
      n_err++;
      $display("FAIL lock_vld_count got=%0d exp=6", vlds);
    end
    n_vec++;
    if (o_locked !== 1'b1 || o_period !== CNT_W'(EXP_PERIOD)) begin
      n_err++;
      $display("FAIL lock_final got lock=%b period=%0d exp lock=1 period=%0d", o_locked, o_period, EXP_PERIOD);
    end
  endtask

  task automatic test_stretch();
    bit saw7;
    saw7 = 1'b0;
    clear_q();
    add_period(3, 4);
    repeat (5) add_period(3, 3);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      if (o_period_vld === 1'b1 && o_period === CNT_W'(7)) saw7 = 1'b1;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL stretch t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (!saw7 || o_locked !== 1'b1 || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL stretch_final got saw7=%b lock=%b err=%b exp 1 1 1", saw7, o_locked, o_err);
    end
  endtask

  task automatic test_stall();
    int vlds;
    vlds = 0;
    clear_q();
    add_level(1'b0, 300);
    repeat (3) add_period(3, 3);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      vlds += int'(o_period_vld);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL stall t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (vlds != 2 || o_locked !== 1'b0 || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL stall_final got vlds=%0d lock=%b err=%b exp 2 0 1", vlds, o_locked, o_err);
    end
  endtask

  task automatic test_err_clr();
    int idx;
    bit err_at_set;
    err_at_set = 1'b0;
    clear_q();
    add_level(1'b0, 3);
    cq[0] = 1'b1;
    repeat (6) add_period(3, 3);
    add_period(3, 5);
    idx = wq.size();
    repeat (3) add_period(3, 3);
    cq[idx] = 1'b1;
    cq[idx + 1] = 1'b1;
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      if (i == 1 && o_err !== 1'b0) begin
        n_vec++; n_err++;
        $display("FAIL err_clr_alone got=%b exp=0", o_err);
      end
      if (i == idx + 1) err_at_set = o_err;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL err_clr t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (err_at_set !== 1'b1) begin
      n_err++;
      $display("FAIL err_set_wins got=%b exp=1", err_at_set);
    end
    step(1'b0, 1'b1, 1'b1);
    n_vec++;
    if (o_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr_final got=%b exp=0", o_err);
    end
  endtask

  task automatic test_back_to_back();
    int rises, falls;
    rises = 0; falls = 0;
    clear_q();
    repeat (12) add_period(1, 1);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      rises += int'(o_rise);
      falls += int'(o_fall);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (rises != 12 || falls != 12) begin
      n_err++;
      $display("FAIL back_to_back_count got rises=%0d falls=%0d exp 12 12", rises, falls);
    end
  endtask

  task automatic test_duty();
    bit ever_locked;
    ever_locked = 1'b0;
    clear_q();
    add_level(1'b0, 3);
    eq[0] = 1'b0; eq[1] = 1'b0; cq[0] = 1'b1; cq[1] = 1'b1;
    repeat (8) add_period(2, 4);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      if (o_locked === 1'b1) ever_locked = 1'b1;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL duty_hi2 t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
`ifdef DIV_CLK_MON_DUTY_EN
    if (ever_locked || o_err !== 1'b0 || o_high !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL duty_hi2_final got locked=%b err=%b high=%0d exp 0 0 2", ever_locked, o_err, o_high);
    end
`else
    if (!ever_locked || o_err !== 1'b0 || o_high !== '0) begin
      n_err++;
      $display("FAIL duty_hi2_final got locked=%b err=%b high=%0d exp 1 0 0", ever_locked, o_err, o_high);
    end
`endif
    clear_q();
    repeat (6) add_period(3, 3);
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL duty_hi3 t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
    n_vec++;
`ifdef DIV_CLK_MON_DUTY_EN
    if (o_locked !== 1'b1 || o_high !== CNT_W'(3)) begin
      n_err++;
      $display("FAIL duty_hi3_final got lock=%b high=%0d exp 1 3", o_locked, o_high);
    end
`else
    if (o_locked !== 1'b1 || o_high !== '0) begin
      n_err++;
      $display("FAIL duty_hi3_final got lock=%b high=%0d exp 1 0", o_locked, o_high);
    end
`endif
  endtask

  task automatic test_random();
    int hi, lo, idx;
    clear_q();
    repeat (150) begin
      if ($urandom_range(0, 9) < 7) begin
        hi = 3; lo = 3;
      end else begin
        hi = $urandom_range(1, 5); lo = $urandom_range(1, 5);
      end
      add_period(hi, lo);
    end
    foreach (cq[i]) if ($urandom_range(0, 63) == 0) cq[i] = 1'b1;
    idx = $urandom_range(100, 400);
    for (int k = 0; k < 3; k++) eq[idx + k] = 1'b0;
    foreach (wq[i]) begin
      step(wq[i], eq[i], cq[i]);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random t=%0d got=%h exp=%h (rise,fall,vld,lock,err,period,high)", mt, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    div_clk = 1'b0; en = 1'b0; err_clr = 1'b0; rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_stuck_high();
    test_lock();
    test_stretch();
    test_stall();
    test_err_clr();
    test_back_to_back();
    test_duty();
    test_random();
    test_stretch();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
